// File: rtl/adxl345_spi_model_if.sv
`default_nettype none
// ============================================================================
//  Module      : adxl345_spi_model_if
//  Description : 4-wire SPI bundle between an SPI master and the ADXL345
//                accelerometer model. It also carries the two interrupt lines.
//                master modport: drives sclk/ncs/sdi, observes sdo/sdo_oe/int*
//                slave  modport: observes sclk/ncs/sdi, drives sdo/sdo_oe/int*
//  Revision    : 1.0  initial release
// ============================================================================
interface adxl345_spi_model_if;
    logic sclk;     // SPI clock, idles high (CPOL=1, CPHA=1)
    logic ncs;      // chip select, active low
    logic sdi;      // master -> slave data
    logic sdo;      // slave -> master data, valid while sdo_oe=1
    logic sdo_oe;   // sdo drive enable
    logic int1;     // interrupt 1, active high
    logic int2;     // interrupt 2, active high

    modport master (
        output sclk, ncs, sdi,
        input  sdo, sdo_oe, int1, int2
    );

    modport slave (
        input  sclk, ncs, sdi,
        output sdo, sdo_oe, int1, int2
    );
endinterface
`default_nettype wire

// File: rtl/adxl345_spi_model.sv
`default_nettype none
// ============================================================================
//  Module      : adxl345_spi_model
//  Description : Behavioural ADXL345-style accelerometer SPI slave.
//                - SPI mode 3 front end, oversampled on clk through 2-FF
//                  synchronisers.
//                - 64-byte register file.
//                - Self-running sample generator with a DATA_READY interrupt
//                  that can be routed to int1 or int2.
//  Ports       : clk    in   system clock (sclk period >= 8 clk periods)
//                reset  in   asynchronous, active-high reset
//                spi    slave modport of adxl345_spi_model_if
//                       (sclk, ncs, sdi in; sdo, sdo_oe, int1, int2 out)
//  Config      : ADXL345_SELF_TEST_EN - when defined, DATA_FORMAT bit7 adds
//                16'h0100 to every axis value returned on a read.
//  Revision    : 1.0  initial release
// ============================================================================
module adxl345_spi_model #(
    parameter int         NUM_AXES      = 3,        // 1..4 axes, 16 bits each
    parameter logic [7:0] DEVID         = 8'hE5,    // value at address 0x00
    parameter logic [5:0] DATA_BASE     = 6'h32,    // AXIS0 low byte address
    parameter int         SAMPLE_PERIOD = 1000      // clks between samples, >=16
) (
    input  logic               clk,
    input  logic               reset,
    adxl345_spi_model_if.slave spi
);

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
    localparam logic [5:0] ADDR_INT_MAP     = 6'h2F;
    localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
`ifdef ADXL345_SELF_TEST_EN
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
`endif

    // Number of read-only sample bytes and the address whose read clears
    // DATA_READY (high byte of the last modelled axis).
    localparam logic [6:0] DATA_SPAN = 7'(2 * NUM_AXES);
    localparam logic [5:0] DATA_LAST = 6'(7'(DATA_BASE) + DATA_SPAN - 7'd1);

    localparam int             CNT_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // ------------------------------------------------------------------
    // Synchronisers and sclk edge detection
    // ------------------------------------------------------------------
    logic sclk_s1, sclk_s2, sclk_prev;
    logic ncs_s1, ncs_s2;
    logic sdi_s1, sdi_s2;
    logic sclk_rise, sclk_fall;

    assign sclk_rise = sclk_s2 & ~sclk_prev;
    assign sclk_fall = ~sclk_s2 & sclk_prev;

    // ------------------------------------------------------------------
    // Transfer state
    // ------------------------------------------------------------------
    logic [2:0]  bit_cnt;     // sclk rises seen in the current byte
    logic [6:0]  shift;       // first seven bits of the byte being received
    logic        rnw;
    logic        mb;
    logic [5:0]  addr;
    logic [7:0]  tx_byte;     // byte being returned to the master
    logic        tx_bit;
    logic        tx_en;

    // ------------------------------------------------------------------
    // Register file, samples, interrupts
    // ------------------------------------------------------------------
    logic [7:0]       regs [0:63];
    logic [15:0]      sample [0:3];
    logic [CNT_W-1:0] cnt;
    logic             pending;
    logic             data_ready;
    logic             int1_reg, int2_reg;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [7:0]  rx_byte;
    logic        in_xfer;
    logic        byte_done;
    logic [5:0]  next_addr;
    logic [5:0]  load_addr;
    logic        load_en;
    logic [7:0]  load_data;
    logic [6:0]  data_off;
    logic [6:0]  wr_off;
    logic [15:0] axis_val;
    logic        write_en;
    logic        dr_clear;
    logic [7:0]  int_source;
    logic        measure;
    logic        tick;
    logic        apply;
    logic        pending_next;

    assign int_source = {data_ready, 7'b0};

    always_comb begin
        rx_byte   = {shift, sdi_s2};
        in_xfer   = (state == CMD) || (state == DATA);
        byte_done = in_xfer && !ncs_s2 && sclk_rise && (bit_cnt == 3'd7);
        next_addr = mb ? addr + 6'd1 : addr;

        // A read byte is latched at the start of the byte: right after the
        // command byte, or right after the previous data byte.
        load_addr = (state == CMD) ? rx_byte[5:0] : next_addr;
        load_en   = byte_done && ((state == CMD) ? rx_byte[7] : rnw);

        // Offset from DATA_BASE; addresses below DATA_BASE wrap to >= 65
        // and therefore fail both data-window compares.
        data_off = {1'b0, load_addr} - {1'b0, DATA_BASE};
        axis_val = sample[data_off[2:1]];
`ifdef ADXL345_SELF_TEST_EN
        if (regs[ADDR_DATA_FORMAT][7]) begin
            axis_val = axis_val + 16'h0100;
        end
`endif

        load_data = regs[load_addr];
        if (load_addr == ADDR_DEVID) begin
            load_data = DEVID;
        end else if (load_addr == ADDR_INT_SOURCE) begin
            load_data = int_source;
        end else if (data_off < DATA_SPAN) begin
            load_data = data_off[0] ? axis_val[15:8] : axis_val[7:0];
        end else if (data_off < 7'd8) begin
            // Axis slots beyond NUM_AXES
            load_data = 8'h00;
        end

        dr_clear = load_en && (load_addr == DATA_LAST);

        wr_off   = {1'b0, addr} - {1'b0, DATA_BASE};
        write_en = byte_done && (state == DATA) && !rnw &&
                   (addr != ADDR_DEVID) && (addr != ADDR_INT_SOURCE) &&
                   !(wr_off < DATA_SPAN);

        // Sample updates are deferred while the master holds ncs low so a
        // burst never sees a torn multi-byte sample set.
        measure      = regs[ADDR_POWER_CTL][3];
        tick         = measure && (cnt == CNT_LAST);
        apply        = measure && ncs_s2 && (tick || pending);
        pending_next = measure && !ncs_s2 && (tick || pending);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (ncs_s2) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = CMD;
                CMD:     if (byte_done) state_next = DATA;
                DATA:    state_next = DATA;
                default: state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // SPI datapath and register writes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_s1   <= 1'b1;
            sclk_s2   <= 1'b1;
            sclk_prev <= 1'b1;
            ncs_s1    <= 1'b1;
            ncs_s2    <= 1'b1;
            sdi_s1    <= 1'b0;
            sdi_s2    <= 1'b0;
            bit_cnt   <= 3'd0;
            shift     <= 7'd0;
            rnw       <= 1'b0;
            mb        <= 1'b0;
            addr      <= 6'd0;
            tx_byte   <= 8'd0;
            tx_bit    <= 1'b0;
            tx_en     <= 1'b0;
            for (int i = 0; i < 64; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            sclk_s1   <= spi.sclk;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            ncs_s1    <= spi.ncs;
            ncs_s2    <= ncs_s1;
            sdi_s1    <= spi.sdi;
            sdi_s2    <= sdi_s1;

            if (ncs_s2) begin
                // Deselect: drop any partial byte and release sdo.
                bit_cnt <= 3'd0;
                tx_en   <= 1'b0;
                tx_bit  <= 1'b0;
            end else if (in_xfer && sclk_rise) begin
                shift   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_done) begin
                    if (state == CMD) begin
                        rnw  <= rx_byte[7];
                        mb   <= rx_byte[6];
                        addr <= rx_byte[5:0];
                    end else begin
                        addr <= next_addr;
                    end
                    if (write_en) begin
                        regs[addr] <= rx_byte;
                    end
                    if (load_en) begin
                        tx_byte <= load_data;
                        tx_bit  <= load_data[7];
                        tx_en   <= 1'b1;
                    end
                end
            end else if (in_xfer && sclk_fall && tx_en) begin
                // First fall of a byte (bit_cnt=0) re-presents the MSB;
                // the k-th rise is followed by bit 7-k.
                tx_bit <= tx_byte[~bit_cnt];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample generator, DATA_READY and interrupt outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            pending    <= 1'b0;
            data_ready <= 1'b0;
            int1_reg   <= 1'b0;
            int2_reg   <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                sample[n] <= 16'h0000;
            end
        end else begin
            if (!measure || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            pending <= pending_next;

            if (apply) begin
                for (int n = 0; n < 4; n++) begin
                    if (n < NUM_AXES) begin
                        sample[n] <= sample[n] + 16'(n + 1);
                    end
                end
            end

            // A new sample in the same clk as the clearing read keeps it set.
            if (apply) begin
                data_ready <= 1'b1;
            end else if (dr_clear) begin
                data_ready <= 1'b0;
            end

            int1_reg <= |(int_source & regs[ADDR_INT_ENABLE] & ~regs[ADDR_INT_MAP]);
            int2_reg <= |(int_source & regs[ADDR_INT_ENABLE] &  regs[ADDR_INT_MAP]);
        end
    end

    assign spi.sdo    = tx_bit;
    assign spi.sdo_oe = tx_en;
    assign spi.int1   = int1_reg;
    assign spi.int2   = int2_reg;

endmodule
`default_nettype wire
